// File: rtl/haar_idwt_stage.sv
// Single-level inverse Haar reconstruction: pairs buffered approximations with
// thresholded details and emits x0 = a + d, x1 = a - d on consecutive clocks.
// Optional macro IDWT_SATURATE_EN: clamp results instead of two's-complement wrap.
//
// state | meaning
// IDLE  | waiting for a detail; a match here pops the FIFO and registers x0
// ODD   | x0 on the output, held x1 goes out next; any detail is an overrun
module haar_idwt_stage #(
    parameter int ADC_WIDTH  = 14,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADC_WIDTH-1:0]          approx_in,
    input  logic                          approx_valid,
    input  logic [ADC_WIDTH-1:0]          detail_in,
    input  logic                          detail_valid,
    input  logic                          reconstruct_en,
    output logic [ADC_WIDTH-1:0]          sample_out,
    output logic                          sample_valid,
    output logic                          sample_phase,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow_err,
    output logic                          underflow_err,
    output logic                          overrun_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ODD  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [ADC_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   fifo_empty;
    logic                   fifo_full;

    logic                   match;
    logic                   emit_x1;
    logic                   underflow_hit;
    logic                   overrun_hit;
    logic                   push;
    logic                   pop;
    logic                   overflow_hit;

    logic [ADC_WIDTH-1:0]   a_head;
    logic [ADC_WIDTH-1:0]   d_eff;
    logic [ADC_WIDTH-1:0]   x0_val;
    logic [ADC_WIDTH-1:0]   x1_val;
    logic [ADC_WIDTH-1:0]   x1_hold;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_level = count;

    always_comb begin
        state_nxt     = state;
        match         = 1'b0;
        emit_x1       = 1'b0;
        underflow_hit = 1'b0;
        overrun_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (detail_valid) begin
                    if (!fifo_empty) begin
                        match     = 1'b1;
                        state_nxt = ODD;
                    end else begin
                        underflow_hit = 1'b1;
                    end
                end
            end
            ODD: begin
                emit_x1   = 1'b1;
                state_nxt = IDLE;
                if (detail_valid) begin
                    overrun_hit = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The pop frees a slot in the same cycle, so push+pop on a full FIFO is legal.
    assign pop          = match;
    assign push         = approx_valid && (!fifo_full || pop);
    assign overflow_hit = approx_valid && fifo_full && !pop;

    assign a_head = mem[rd_ptr];
    assign d_eff  = reconstruct_en ? detail_in : '0;

`ifdef IDWT_SATURATE_EN
    localparam logic [ADC_WIDTH-1:0] SAT_MAX = {1'b0, {(ADC_WIDTH-1){1'b1}}};
    localparam logic [ADC_WIDTH-1:0] SAT_MIN = {1'b1, {(ADC_WIDTH-1){1'b0}}};

    logic [ADC_WIDTH:0] sum_w;
    logic [ADC_WIDTH:0] diff_w;

    assign sum_w  = {a_head[ADC_WIDTH-1], a_head} + {d_eff[ADC_WIDTH-1], d_eff};
    assign diff_w = {a_head[ADC_WIDTH-1], a_head} - {d_eff[ADC_WIDTH-1], d_eff};

    // Top two bits disagree only when the result left the ADC_WIDTH range.
    always_comb begin
        x0_val = sum_w[ADC_WIDTH-1:0];
        x1_val = diff_w[ADC_WIDTH-1:0];
        if (sum_w[ADC_WIDTH] != sum_w[ADC_WIDTH-1]) begin
            x0_val = sum_w[ADC_WIDTH] ? SAT_MIN : SAT_MAX;
        end
        if (diff_w[ADC_WIDTH] != diff_w[ADC_WIDTH-1]) begin
            x1_val = diff_w[ADC_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign x0_val = a_head + d_eff;
    assign x1_val = a_head - d_eff;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= approx_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            sample_out    <= '0;
            sample_valid  <= 1'b0;
            sample_phase  <= 1'b0;
            x1_hold       <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            sample_valid <= match || emit_x1;
            if (match) begin
                sample_out   <= x0_val;
                sample_phase <= 1'b0;
                x1_hold      <= x1_val;
            end else if (emit_x1) begin
                sample_out   <= x1_hold;
                sample_phase <= 1'b1;
            end

            if (overflow_hit)  overflow_err  <= 1'b1;
            if (underflow_hit) underflow_err <= 1'b1;
            if (overrun_hit)   overrun_err   <= 1'b1;
        end
    end

endmodule
